// File: rtl/pulse_seq_timer_if.sv
// pulse_seq_timer_if: controller/pulse-generator bundle for the tick-driven pulse sequencer
interface pulse_seq_timer_if #(
  parameter int CNT_W     = 8,
  parameter int NUM_PULSE = 4,
  parameter int IDX_W     = 2
);
  logic                       tick_in;
  logic                       enable;
  logic                       state_start;
  logic                       repeat_mode;
  logic [CNT_W-1:0]           period_val;
  logic [NUM_PULSE*CNT_W-1:0] pulse_at;
  logic [NUM_PULSE-1:0]       pulse_mask;
  logic                       start;
  logic [NUM_PULSE-1:0]       hit_vec;
  logic [IDX_W-1:0]           pulse_idx;
  logic [CNT_W-1:0]           cnt;
  logic                       busy;
  logic                       done;
  logic                       wrap;
  modport master (
    output tick_in, enable, state_start, repeat_mode, period_val, pulse_at, pulse_mask,
    input  start, hit_vec, pulse_idx, cnt, busy, done, wrap
  );
  modport slave (
    input  tick_in, enable, state_start, repeat_mode, period_val, pulse_at, pulse_mask,
    output start, hit_vec, pulse_idx, cnt, busy, done, wrap
  );
endinterface

// File: rtl/pulse_seq_timer.sv
// pulse_seq_timer: counts synchronised slow ticks and strobes start at programmable offsets
module pulse_seq_timer #(
  parameter int CNT_W     = 8,
  parameter int NUM_PULSE = 4,
  parameter int IDX_W     = 2
) (
  input logic              clk_sys,
  input logic              rst,
  pulse_seq_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state_q;
  logic [2:0]           sync_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 start_q;
  logic                 wrap_q;
  logic [NUM_PULSE-1:0] hit_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 tick_en;
  logic [CNT_W-1:0]     eff_period;
  logic [NUM_PULSE-1:0] hit;
  logic [IDX_W-1:0]     low_idx;
  assign tick_en    = sync_q[1] & ~sync_q[2];
  assign eff_period = (bus.period_val == '0) ? '1 : bus.period_val;
  // cnt_q is always 0 in IDLE, so an arming tick evaluates offset 0 naturally
  always_comb begin
    hit     = '0;
    low_idx = '0;
    for (int i = 0; i < NUM_PULSE; i++)
      hit[i] = bus.pulse_mask[i] & (bus.pulse_at[i*CNT_W +: CNT_W] == cnt_q);
    for (int i = NUM_PULSE - 1; i >= 0; i--)
      if (hit[i]) low_idx = IDX_W'(i);
  end
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      wrap_q  <= 1'b0;
      hit_q   <= '0;
      idx_q   <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], bus.tick_in};
      start_q <= 1'b0;
      wrap_q  <= 1'b0;
      hit_q   <= '0;
      if (!bus.enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (tick_en) begin
        if (!bus.state_start) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if (state_q != DONE) begin
          if (|hit) begin
            start_q <= 1'b1;
            hit_q   <= hit;
            idx_q   <= low_idx;
          end
          if (cnt_q == eff_period) begin
            state_q <= bus.repeat_mode ? RUN : DONE;
            cnt_q   <= bus.repeat_mode ? '0 : cnt_q;
            wrap_q  <= bus.repeat_mode;
          end else begin
            state_q <= RUN;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
      end
    end
  end
  assign bus.start     = start_q;
  assign bus.hit_vec   = hit_q;
  assign bus.pulse_idx = idx_q;
  assign bus.cnt       = cnt_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.wrap      = wrap_q;
endmodule
